// File: rtl/head_soccer_sprite_scheduler.sv
// Frame-synchronous sprite update scheduler: round-robin admits game-logic updates
// into shadow registers, committed to live outputs at vblank start. Optional: HS_SCHED_CLAMP_EN.
module head_soccer_sprite_scheduler #(
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned C1_X0    = 100,
  parameter int unsigned C1_Y0    = 380,
  parameter int unsigned C2_X0    = 500,
  parameter int unsigned C2_Y0    = 380,
  parameter int unsigned CHAR_S0  = 40,
  parameter int unsigned BALL_X0  = 320,
  parameter int unsigned BALL_Y0  = 200,
  parameter int unsigned BALL_S0  = 8
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [29:0] req_x,
  input  logic [29:0] req_y,
  input  logic [29:0] req_s,
  output logic [9:0]  Char1X,
  output logic [9:0]  Char1Y,
  output logic [9:0]  Char1S,
  output logic [9:0]  Char2X,
  output logic [9:0]  Char2Y,
  output logic [9:0]  Char2S,
  output logic [9:0]  BallX,
  output logic [9:0]  BallY,
  output logic [9:0]  BallS,
  output logic        frame_tick,
  output logic [2:0]  pending
);

  localparam int unsigned CW   = 10;
  localparam int unsigned NREQ = 3;

  localparam logic [NREQ-1:0][CW-1:0] X_RST = {CW'(BALL_X0), CW'(C2_X0), CW'(C1_X0)};
  localparam logic [NREQ-1:0][CW-1:0] Y_RST = {CW'(BALL_Y0), CW'(C2_Y0), CW'(C1_Y0)};
  localparam logic [NREQ-1:0][CW-1:0] S_RST = {CW'(BALL_S0), CW'(CHAR_S0), CW'(CHAR_S0)};

  typedef enum logic {ACCEPT, COMMIT} state_t;

  state_t                    state;
  logic [1:0]                rr_ptr;
  logic                      vblank, vblank_d, vb_rise;
  logic [NREQ-1:0][CW-1:0]   sh_x, sh_y, sh_s;
  logic [NREQ-1:0][CW-1:0]   lv_x, lv_y, lv_s;
  logic [NREQ-1:0][CW-1:0]   in_x, in_y, in_s;
  logic [1:0]                o0, o1, o2, gnt_idx;
  logic                      gnt_vld;
  logic                      cfg_unused;

  // DrawX is carried for visibility only; H_ACTIVE matters only with clamping.
  assign cfg_unused = ^{DrawX, CW'(H_ACTIVE)};

  assign vblank  = (DrawY >= CW'(V_ACTIVE));
  assign vb_rise = vblank & ~vblank_d;

`ifdef HS_SCHED_CLAMP_EN
  // Saturate incoming values to the visible area and a 63-pixel max size.
  always_comb begin
    in_x = '0;
    in_y = '0;
    in_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      in_x[i] = (req_x[i*CW +: CW] > CW'(H_ACTIVE - 1)) ? CW'(H_ACTIVE - 1) : req_x[i*CW +: CW];
      in_y[i] = (req_y[i*CW +: CW] > CW'(V_ACTIVE - 1)) ? CW'(V_ACTIVE - 1) : req_y[i*CW +: CW];
      in_s[i] = (req_s[i*CW +: CW] > CW'(63)) ? CW'(63) : req_s[i*CW +: CW];
    end
  end
`else
  assign in_x = req_x;
  assign in_y = req_y;
  assign in_s = req_s;
`endif

  // Round-robin search order starts just after the last winner.
  always_comb begin
    o0 = 2'd0;
    o1 = 2'd1;
    o2 = 2'd2;
    case (rr_ptr)
      2'd0: begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1: begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    gnt_vld = 1'b1;
    gnt_idx = o0;
    if (req_valid[o0])      gnt_idx = o0;
    else if (req_valid[o1]) gnt_idx = o1;
    else begin
      gnt_idx = o2;
      gnt_vld = req_valid[o2];
    end
  end

  assign req_ready = (state == ACCEPT && gnt_vld) ? (3'b001 << gnt_idx) : 3'b000;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state      <= ACCEPT;
      rr_ptr     <= 2'd2;
      pending    <= '0;
      frame_tick <= 1'b0;
      vblank_d   <= 1'b1;
      sh_x       <= X_RST;
      sh_y       <= Y_RST;
      sh_s       <= S_RST;
      lv_x       <= X_RST;
      lv_y       <= Y_RST;
      lv_s       <= S_RST;
    end else begin
      vblank_d   <= vblank;
      frame_tick <= 1'b0;
      case (state)
        ACCEPT: begin
          if (gnt_vld) begin
            sh_x[gnt_idx]    <= in_x[gnt_idx];
            sh_y[gnt_idx]    <= in_y[gnt_idx];
            sh_s[gnt_idx]    <= in_s[gnt_idx];
            pending[gnt_idx] <= 1'b1;
            rr_ptr           <= gnt_idx;
          end
          if (vb_rise) begin
            state      <= COMMIT;
            frame_tick <= 1'b1;
          end
        end
        COMMIT: begin
          // Only slots with a fresh update move; the rest keep their live values.
          for (int i = 0; i < NREQ; i++) begin
            if (pending[i]) begin
              lv_x[i] <= sh_x[i];
              lv_y[i] <= sh_y[i];
              lv_s[i] <= sh_s[i];
            end
          end
          pending <= '0;
          state   <= ACCEPT;
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  assign Char1X = lv_x[0];
  assign Char1Y = lv_y[0];
  assign Char1S = lv_s[0];
  assign Char2X = lv_x[1];
  assign Char2Y = lv_y[1];
  assign Char2S = lv_s[1];
  assign BallX  = lv_x[2];
  assign BallY  = lv_y[2];
  assign BallS  = lv_s[2];

endmodule

// File: tb/tb_head_soccer_sprite_scheduler.sv
// Scoreboard bench for head_soccer_sprite_scheduler: expected grants and commits
// are queued by the stimulus, and a monitor compares them as the DUT produces them.
module tb_head_soccer_sprite_scheduler;

  typedef logic [8:0][9:0] live_t;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = 10'd100;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [29:0] req_x = '0, req_y = '0, req_s = '0;
  logic [9:0]  Char1X, Char1Y, Char1S, Char2X, Char2Y, Char2S, BallX, BallY, BallS;
  logic        frame_tick;
  logic [2:0]  pending;

  int tests = 0;
  int fails = 0;

  logic [2:0] exp_grant_q[$];
  live_t      exp_live_q[$];
  logic       tick_d = 1'b0;

  head_soccer_sprite_scheduler dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_s(req_s),
    .Char1X(Char1X), .Char1Y(Char1Y), .Char1S(Char1S),
    .Char2X(Char2X), .Char2Y(Char2Y), .Char2S(Char2S),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .frame_tick(frame_tick), .pending(pending)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic live_t mk(int c1x, int c1y, int c1s, int c2x, int c2y, int c2s,
                               int bx, int by, int bs);
    return {10'(bs), 10'(by), 10'(bx), 10'(c2s), 10'(c2y), 10'(c2x),
            10'(c1s), 10'(c1y), 10'(c1x)};
  endfunction

  // Monitor: pops an expected grant whenever req_ready fires, and an expected
  // live snapshot on the cycle after each frame_tick pulse.
  always @(negedge vga_clk) begin
    live_t act, e;
    string nm[9];
    nm = '{"Char1X", "Char1Y", "Char1S", "Char2X", "Char2Y", "Char2S", "BallX", "BallY", "BallS"};
    if (reset) begin
      tick_d = 1'b0;
    end else begin
      if (tick_d) begin
        if (exp_live_q.size() == 0) begin
          check("unexpected_commit", 1, 0);
        end else begin
          e   = exp_live_q.pop_front();
          act = {BallS, BallY, BallX, Char2S, Char2Y, Char2X, Char1S, Char1Y, Char1X};
          for (int k = 0; k < 9; k++) check({"commit_", nm[k]}, int'(act[k]), int'(e[k]));
          check("commit_pending_clear", int'(pending), 0);
        end
      end
      if (req_ready != 3'b000) begin
        if (exp_grant_q.size() == 0) check("unexpected_grant", int'(req_ready), 0);
        else check("grant", int'(req_ready), int'(exp_grant_q.pop_front()));
      end
      tick_d = frame_tick;
    end
  end

  task automatic set_req(input int i, input int x, input int y, input int s);
    req_x[i*10 +: 10] = 10'(x);
    req_y[i*10 +: 10] = 10'(y);
    req_s[i*10 +: 10] = 10'(s);
  endtask

  task automatic send(input int i, input int x, input int y, input int s);
    bit ok;
    @(posedge vga_clk); #1;
    set_req(i, x, y, s);
    req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge vga_clk);
      if (req_ready[i]) ok = 1'b1;
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge vga_clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic do_vblank();
    bit seen;
    @(posedge vga_clk); #1 DrawY = 10'd479;
    @(posedge vga_clk); #1 DrawY = 10'd480;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge vga_clk);
      if (frame_tick) seen = 1'b1;
    end
    if (!seen) check("vblank_timeout", 0, 1);
    @(negedge vga_clk); #1;
    DrawY = 10'd100;
    @(posedge vga_clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge vga_clk);
    #1 reset = 1'b0;
    @(negedge vga_clk);
    check("rst_Char1X", int'(Char1X), 100);
    check("rst_Char2X", int'(Char2X), 500);
    check("rst_BallX", int'(BallX), 320);
    check("rst_BallS", int'(BallS), 8);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_frame_tick", int'(frame_tick), 0);

    // Ball update held in shadow until vblank
    exp_grant_q.push_back(3'b100);
    send(2, 50, 60, 8);
    @(negedge vga_clk);
    check("ball_pending", int'(pending), 4);
    check("ball_no_tear", int'(BallX), 320);
    exp_live_q.push_back(mk(100, 380, 40, 500, 380, 40, 50, 60, 8));
    do_vblank();

    // Round-robin with all requesters valid
    @(posedge vga_clk); #1;
    set_req(0, 11, 301, 30);
    set_req(1, 12, 302, 32);
    set_req(2, 13, 303, 9);
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b010);
    exp_grant_q.push_back(3'b100);
    exp_grant_q.push_back(3'b001);
    req_valid = 3'b111;
    repeat (4) @(posedge vga_clk);
    #1 req_valid = 3'b000;
    @(negedge vga_clk);
    check("rr_pending", int'(pending), 7);
    exp_live_q.push_back(mk(11, 301, 30, 12, 302, 32, 13, 303, 9));
    do_vblank();

    // Last write wins within a frame
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b001);
    send(0, 10, 380, 40);
    send(0, 20, 380, 40);
    @(negedge vga_clk);
    check("lww_pending", int'(pending), 1);
    exp_live_q.push_back(mk(20, 380, 40, 12, 302, 32, 13, 303, 9));
    do_vblank();

    // Transfer on the vb_rise cycle, then a retry that stalls through COMMIT
    exp_grant_q.push_back(3'b001);
    exp_live_q.push_back(mk(77, 380, 40, 12, 302, 32, 13, 303, 9));
    exp_grant_q.push_back(3'b001);
    @(posedge vga_clk); #1 DrawY = 10'd479;
    @(posedge vga_clk); #1 DrawY = 10'd480;
    set_req(0, 77, 380, 40);
    req_valid[0] = 1'b1;
    @(posedge vga_clk); #1 set_req(0, 88, 380, 40);
    @(negedge vga_clk);
    check("commit_ready_low", int'(req_ready), 0);
    check("commit_tick", int'(frame_tick), 1);
    @(posedge vga_clk);
    @(negedge vga_clk);
    @(posedge vga_clk); #1;
    req_valid[0] = 1'b0;
    DrawY = 10'd100;
    @(negedge vga_clk);
    check("retry_pending", int'(pending), 1);
    exp_live_q.push_back(mk(88, 380, 40, 12, 302, 32, 13, 303, 9));
    do_vblank();

    // Out-of-range values: saturated with clamping, raw otherwise
    exp_grant_q.push_back(3'b100);
    send(2, 700, 900, 100);
`ifdef HS_SCHED_CLAMP_EN
    exp_live_q.push_back(mk(88, 380, 40, 12, 302, 32, 639, 479, 63));
`else
    exp_live_q.push_back(mk(88, 380, 40, 12, 302, 32, 700, 900, 100));
`endif
    do_vblank();

    // Reset with every slot pending discards the updates
    @(posedge vga_clk); #1;
    set_req(0, 1, 2, 3);
    set_req(1, 4, 5, 6);
    set_req(2, 7, 8, 9);
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b010);
    exp_grant_q.push_back(3'b100);
    req_valid = 3'b111;
    repeat (3) @(posedge vga_clk);
    #1 req_valid = 3'b000;
    @(negedge vga_clk);
    check("pre_rst_pending", int'(pending), 7);
    @(posedge vga_clk); #1 reset = 1'b1;
    @(posedge vga_clk);
    @(negedge vga_clk);
    check("mid_rst_pending", int'(pending), 0);
    check("mid_rst_tick", int'(frame_tick), 0);
    check("mid_rst_Char1X", int'(Char1X), 100);
    check("mid_rst_Char2Y", int'(Char2Y), 380);
    check("mid_rst_BallX", int'(BallX), 320);
    check("mid_rst_BallY", int'(BallY), 200);
    @(posedge vga_clk); #1 reset = 1'b0;
    repeat (3) @(negedge vga_clk);
    check("post_rst_tick", int'(frame_tick), 0);
    exp_live_q.push_back(mk(100, 380, 40, 500, 380, 40, 320, 200, 8));
    do_vblank();

    repeat (3) @(negedge vga_clk);
    check("grants_drained", exp_grant_q.size(), 0);
    check("commits_drained", exp_live_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/head_soccer_sprite_scheduler.md
Name: head_soccer_sprite_scheduler

Overview:
- Frame-synchronous update controller for the sprite renderer's position/size inputs (Char1X/Y/S, Char2X/Y/S, BallX/Y/S).
- Three game-logic requesters (player 1, player 2, ball physics) submit updates over valid/ready; a round-robin arbiter admits one per cycle into shadow registers.
- Shadow values are committed to the live outputs only at vertical-blank start, so a sprite never tears mid-frame.
- Sits between game logic and the renderer, in the vga_clk domain.

Parameters:
- V_ACTIVE, 480, first non-visible line; vblank when DrawY >= V_ACTIVE
- H_ACTIVE, 640, visible width; used only by clamp feature
- C1_X0, 100, reset X of character 1
- C1_Y0, 380, reset Y of character 1
- C2_X0, 500, reset X of character 2
- C2_Y0, 380, reset Y of character 2
- CHAR_S0, 40, reset S of both characters
- BALL_X0, 320, reset X of ball
- BALL_Y0, 200, reset Y of ball
- BALL_S0, 8, reset S of ball

Ports:
- vga_clk  in  1  pixel clock, sole clock
- reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel X from VGA controller (unused except by test visibility)
- DrawY  in  10  current pixel Y
- req_valid  in  3  bit i = requester i has an update (0=char1, 1=char2, 2=ball)
- req_ready  out  3  bit i = update from requester i accepted this cycle
- req_x  in  30  {x2,x1,x0}, 10 bits each
- req_y  in  30  {y2,y1,y0}
- req_s  in  30  {s2,s1,s0}
- Char1X, Char1Y, Char1S  out  10 each  live character 1 values
- Char2X, Char2Y, Char2S  out  10 each  live character 2 values
- BallX, BallY, BallS  out  10 each  live ball values
- frame_tick  out  1  one-cycle pulse in the commit cycle
- pending  out  3  shadow slot i holds an uncommitted update

Behaviour:
- Reset (synchronous): live and shadow registers = parameter defaults; pending = 0; rr_ptr = 2 (so requester 0 wins first); state = ACCEPT; frame_tick = 0; vblank_d = 1 (no spurious commit straight out of reset).
- vblank = (DrawY >= V_ACTIVE); vblank_d is its registered copy; vb_rise = vblank & ~vblank_d.
- FSM states:
  - ACCEPT:
    - Grant is combinational: first valid index searching rr_ptr+1, rr_ptr+2, rr_ptr (mod 3).
    - req_ready = one-hot of the grant; 0 if no valid requester.
    - On transfer (valid & ready): shadow[i] <= {x,y,s}; pending[i] <= 1; rr_ptr <= i.
    - If vb_rise, go to COMMIT next cycle.
  - COMMIT (exactly 1 cycle):
    - req_ready = 0.
    - For each i with pending[i]: live[i] <= shadow[i]; pending <= 0.
    - frame_tick = 1; go to ACCEPT.
- A transfer in the same cycle as vb_rise is written to shadow and included in the following commit.
- A second transfer from the same requester before commit overwrites its shadow (last write wins).
- Slots with pending = 0 keep their live values unchanged.
- Live outputs change only on the cycle after COMMIT (registered), i.e. 2 cycles after the first vblank line is presented.
- Each requester holds its data stable while valid & ~ready. The arbiter may drop or reassign a grant between cycles; no lock is held.
- Reset mid-frame or during COMMIT: everything returns to reset values; uncommitted updates are discarded.
- All arithmetic is 10-bit unsigned; values are not modified unless the clamp feature is enabled.

Optional Feature:
- Macro: HS_SCHED_CLAMP_EN
- When defined, values are clamped on write into shadow:
  - x = min(x, H_ACTIVE-1)
  - y = min(y, V_ACTIVE-1)
  - s = min(s, 63)
- When undefined, shadow stores the raw request values.

Test Plan:
- Reset with DrawY=100 -> outputs show Char1X=100, Char2X=500, BallX=320, BallS=8; req_ready=0; pending=0; frame_tick=0.
- Requester 2 sends x=50,y=60,s=8 at DrawY=100 -> req_ready=3'b100 for 1 cycle, pending=3'b100, BallX stays 320. DrawY steps 479->480 -> frame_tick pulses once, then BallX=50, BallY=60, pending=0.
- All three valid continuously after reset -> grants 3'b001, 3'b010, 3'b100, 3'b001 on consecutive cycles.
- Requester 0 writes x=10 then x=20 before vblank -> Char1X becomes 20 after commit.
- Transfer x=77 on the exact vb_rise cycle -> Char1X=77 after that commit. A request during COMMIT sees req_ready=0 and is accepted the next cycle.
- With HS_SCHED_CLAMP_EN, request x=700, y=900, s=100 -> committed 639, 479, 63. Assert reset while pending=3'b111 -> pending=0 and defaults are restored with no frame_tick.
